// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cacheline_adaptor_if : line-request and burst-memory bus bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic              u_read;
  logic              u_write;
  logic [ADDR_W-1:0] u_address;
  logic [LINE_W-1:0] u_wdata;
  logic [LINE_W-1:0] u_rdata;
  logic              u_resp;

  logic               m_read;
  logic               m_write;
  logic [ADDR_W-1:0]  m_address;
  logic [BURST_W-1:0] m_wdata;
  logic [BURST_W-1:0] m_rdata;
  logic               m_resp;

  // master: the environment (cache side and memory side); slave: the adaptor
  modport master (
    output u_read, u_write, u_address, u_wdata, m_rdata, m_resp,
    input  u_rdata, u_resp, m_read, m_write, m_address, m_wdata
  );

  modport slave (
    input  u_read, u_write, u_address, u_wdata, m_rdata, m_resp,
    output u_rdata, u_resp, m_read, m_write, m_address, m_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cacheline_adaptor : splits line reads/writes into sequential memory beats
// Rev 1.0
// ---------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LINE_W / 8) - 1'b1);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic              u_resp_q, u_resp_d;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    m_read_d  = 1'b0;
    m_write_d = 1'b0;
    u_resp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // read has priority if upstream raises both
        if (bus.u_read) begin
          addr_d   = bus.u_address & ALIGN_MASK;
          beat_d   = '0;
          state_d  = READ;
          m_read_d = 1'b1;
        end else if (bus.u_write) begin
          addr_d    = bus.u_address & ALIGN_MASK;
          wdata_d   = bus.u_wdata;
          beat_d    = '0;
          state_d   = WRITE;
          m_write_d = 1'b1;
        end
      end
      READ: begin
        m_read_d = 1'b1;
        if (bus.m_resp) begin
          rdata_d[beat_q*BURST_W +: BURST_W] = bus.m_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            state_d  = DONE;
            m_read_d = 1'b0;
            u_resp_d = 1'b1;
          end
        end
      end
      WRITE: begin
        m_write_d = 1'b1;
        if (bus.m_resp) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            state_d   = DONE;
            m_write_d = 1'b0;
            u_resp_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      u_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      u_resp_q  <= u_resp_d;
    end
  end

  assign bus.m_read    = m_read_q;
  assign bus.m_write   = m_write_q;
  assign bus.u_resp    = u_resp_q;
  assign bus.u_rdata   = rdata_q;
  assign bus.m_address = (m_read_q || m_write_q) ? addr_q : '0;
  assign bus.m_wdata   = wdata_q[beat_q*BURST_W +: BURST_W];
endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor : scoreboard bench for line-to-beat conversion
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmp_n = 0;
  int err_n = 0;

  logic [LINE_W-1:0]  rd_q[$];
  logic [BURST_W-1:0] wr_q[$];

  int                obs_resp;
  logic [31:0]       obs_rd;
  logic [31:0]       obs_wr;
  logic [ADDR_W-1:0] obs_addr;
  int                obs_addr_err;
  logic [LINE_W-1:0] last_rd;

  localparam logic [LINE_W-1:0] READ_LINE =
    {64'hDDDD_DDDD_DDDD_DDD3, 64'hCCCC_CCCC_CCCC_CCC2,
     64'hBBBB_BBBB_BBBB_BBB1, 64'hAAAA_AAAA_AAAA_AAA0};
  localparam logic [LINE_W-1:0] WRITE_LINE =
    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
     64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEEF};

  // One transaction: cycle 0 presents the request; mask bit c drives m_resp in cycle c.
  task automatic run_txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] line, input logic [31:0] mask,
                         input int chg_cyc, input int rst_cyc);
    logic [ADDR_W-1:0]  exp_addr;
    logic [BURST_W-1:0] exp_beat;
    int beat;
    exp_addr     = addr & 32'hFFFF_FFE0;
    obs_resp     = -1;
    obs_rd       = '0;
    obs_wr       = '0;
    obs_addr     = '0;
    obs_addr_err = 0;
    beat         = 0;
    @(posedge clk); #1;
    bus.u_read    = rd;
    bus.u_write   = wr;
    bus.u_address = addr;
    bus.u_wdata   = line;
    bus.m_resp    = 1'b0;
    if (rd) rd_q.push_back(line);
    else if (wr) for (int i = 0; i < BEATS; i++) wr_q.push_back(line[i*BURST_W +: BURST_W]);
    for (int c = 1; c < 32; c++) begin
      @(posedge clk); #1;
      if (c == chg_cyc) begin
        bus.u_address = ~addr;
        bus.u_wdata   = ~line;
      end
      if (c == rst_cyc) rst = 1'b1;
      bus.m_resp  = mask[c];
      bus.m_rdata = (mask[c] && beat < BEATS) ? line[beat*BURST_W +: BURST_W]
                                              : {$urandom(), $urandom()};
      @(negedge clk);
      obs_rd[c] = bus.m_read;
      obs_wr[c] = bus.m_write;
      if (c == 1) obs_addr = bus.m_address;
      if ((bus.m_read || bus.m_write) && bus.m_address !== exp_addr) obs_addr_err++;
      if (bus.m_resp && bus.m_write) begin
        cmp_n++;
        if (wr_q.size() == 0) begin
          err_n++;
          $display("FAIL wdata_extra: cycle %0d m_wdata=%h, required no beat", c, bus.m_wdata);
        end else begin
          exp_beat = wr_q.pop_front();
          if (bus.m_wdata !== exp_beat) begin
            err_n++;
            $display("FAIL wdata_beat: cycle %0d m_wdata=%h, required %h", c, bus.m_wdata, exp_beat);
          end
        end
      end
      if (bus.m_resp) beat++;
      if (bus.u_resp === 1'b1) begin
        obs_resp = c;
        if (rd) begin
          cmp_n++;
          if (rd_q.size() == 0) begin
            err_n++;
            $display("FAIL rdata_extra: u_rdata=%h with empty scoreboard", bus.u_rdata);
          end else begin
            last_rd = rd_q.pop_front();
            if (bus.u_rdata !== last_rd) begin
              err_n++;
              $display("FAIL rdata_line: u_rdata=%h, required %h", bus.u_rdata, last_rd);
            end
          end
        end
        break;
      end
      if (c == rst_cyc) break;
    end
    if (obs_resp < 0 && rst_cyc < 0) begin
      cmp_n++;
      err_n++;
      $display("FAIL timeout: no u_resp within 31 cycles");
    end
    @(posedge clk); #1;
    bus.u_read  = 1'b0;
    bus.u_write = 1'b0;
    bus.m_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_n++;
    if ({bus.u_resp, bus.m_read, bus.m_write} !== 3'b000) begin
      err_n++;
      $display("FAIL reset_ctrl: {u_resp,m_read,m_write}=%b, required 000",
               {bus.u_resp, bus.m_read, bus.m_write});
    end
    cmp_n++;
    if (bus.m_address !== '0) begin
      err_n++;
      $display("FAIL reset_addr: m_address=%h, required 0", bus.m_address);
    end
    cmp_n++;
    if (bus.u_rdata !== '0) begin
      err_n++;
      $display("FAIL reset_rdata: u_rdata=%h, required 0", bus.u_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
  endtask

  task automatic test_read();
    run_txn(1'b1, 1'b0, 32'h0000_1234, READ_LINE, 32'h0000_001E, -1, -1);
    cmp_n++;
    if (obs_addr !== 32'h0000_1220 || obs_addr_err != 0) begin
      err_n++;
      $display("FAIL read_addr: m_address=%h errs=%0d, required 00001220", obs_addr, obs_addr_err);
    end
    cmp_n++;
    if (obs_rd !== 32'h0000_001E || obs_wr !== 32'h0) begin
      err_n++;
      $display("FAIL read_mread: m_read cycles=%h m_write cycles=%h, required 1e/0", obs_rd, obs_wr);
    end
    cmp_n++;
    if (obs_resp != 5) begin
      err_n++;
      $display("FAIL read_latency: u_resp cycle=%0d, required 5", obs_resp);
    end
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b1, 32'h8000_0040, WRITE_LINE, 32'h0000_001E, -1, -1);
    cmp_n++;
    if (obs_resp != 5 || obs_wr !== 32'h0000_001E || wr_q.size() != 0) begin
      err_n++;
      $display("FAIL write_seq: u_resp cycle=%0d m_write cycles=%h left=%0d, required 5/1e/0",
               obs_resp, obs_wr, wr_q.size());
    end
    cmp_n++;
    if (obs_addr !== 32'h8000_0040 || obs_addr_err != 0) begin
      err_n++;
      $display("FAIL write_addr: m_address=%h errs=%0d, required 80000040", obs_addr, obs_addr_err);
    end
    @(negedge clk);
    cmp_n++;
    if (bus.u_rdata !== last_rd) begin
      err_n++;
      $display("FAIL write_rdata_hold: u_rdata=%h, required %h", bus.u_rdata, last_rd);
    end
  endtask

  task automatic test_gaps();
    logic [LINE_W-1:0] line;
    line = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
            64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    run_txn(1'b1, 1'b0, 32'h0000_0100, line, 32'h0000_0264, -1, -1);
    cmp_n++;
    if (obs_resp != 10) begin
      err_n++;
      $display("FAIL gaps_latency: u_resp cycle=%0d, required 10", obs_resp);
    end
    cmp_n++;
    if (obs_rd !== 32'h0000_03FE) begin
      err_n++;
      $display("FAIL gaps_mread: m_read cycles=%h, required 3fe", obs_rd);
    end
  endtask

  task automatic test_both_and_stray();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.m_resp  = 1'b1;
      bus.m_rdata = {$urandom(), $urandom()};
      @(negedge clk);
      cmp_n++;
      if ({bus.u_resp, bus.m_read, bus.m_write} !== 3'b000 || bus.u_rdata !== last_rd) begin
        err_n++;
        $display("FAIL stray_resp: {u_resp,m_read,m_write}=%b u_rdata=%h, required 000/%h",
                 {bus.u_resp, bus.m_read, bus.m_write}, bus.u_rdata, last_rd);
      end
    end
    @(posedge clk); #1;
    bus.m_resp = 1'b0;
    run_txn(1'b1, 1'b1, 32'h0000_3000, ~READ_LINE, 32'h0000_001E, -1, -1);
    cmp_n++;
    if (obs_wr !== 32'h0 || obs_rd !== 32'h0000_001E || obs_resp != 5) begin
      err_n++;
      $display("FAIL both_req: m_write cycles=%h m_read cycles=%h resp=%0d, required 0/1e/5",
               obs_wr, obs_rd, obs_resp);
    end
  endtask

  task automatic test_reset_mid_write();
    run_txn(1'b0, 1'b1, 32'h0000_4000, WRITE_LINE, 32'h0000_001E, -1, 3);
    cmp_n++;
    if (obs_wr[3:1] !== 3'b011 || obs_resp != -1) begin
      err_n++;
      $display("FAIL rst_mid_write: m_write cycles 3..1=%b resp=%0d, required 011/-1",
               obs_wr[3:1], obs_resp);
    end
    wr_q.delete();
    @(negedge clk);
    cmp_n++;
    if (bus.u_resp !== 1'b0 || bus.u_rdata !== '0) begin
      err_n++;
      $display("FAIL rst_mid_state: u_resp=%b u_rdata=%h, required 0/0", bus.u_resp, bus.u_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    run_txn(1'b1, 1'b0, 32'h0000_5010, READ_LINE ^ WRITE_LINE, 32'h0000_001E, -1, -1);
    cmp_n++;
    if (obs_resp != 5) begin
      err_n++;
      $display("FAIL rst_fresh_read: u_resp cycle=%0d, required 5", obs_resp);
    end
  endtask

  task automatic test_input_change();
    run_txn(1'b1, 1'b0, 32'h0000_2045, READ_LINE, 32'h0000_001E, 1, -1);
    cmp_n++;
    if (obs_addr !== 32'h0000_2040 || obs_addr_err != 0) begin
      err_n++;
      $display("FAIL change_raddr: m_address=%h errs=%0d, required 00002040", obs_addr, obs_addr_err);
    end
    run_txn(1'b0, 1'b1, 32'h8000_0040, WRITE_LINE, 32'h0000_001E, 1, -1);
    cmp_n++;
    if (obs_addr !== 32'h8000_0040 || obs_addr_err != 0 || obs_resp != 5) begin
      err_n++;
      $display("FAIL change_waddr: m_address=%h errs=%0d resp=%0d, required 80000040/0/5",
               obs_addr, obs_addr_err, obs_resp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.u_read    = 1'b0;
    bus.u_write   = 1'b0;
    bus.u_address = '0;
    bus.u_wdata   = '0;
    bus.m_rdata   = '0;
    bus.m_resp    = 1'b0;
    last_rd       = '0;
    test_reset();
    test_read();
    test_write();
    test_gaps();
    test_both_and_stray();
    test_reset_mid_write();
    test_input_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the eviction write buffer and L2 path, between full-line cache requests and the burst-oriented physical memory.
- Converts one LINE_W-bit line read or write into LINE_W/BURST_W sequential BURST_W-bit beats.
- Reassembles read beats into a line and returns a single-cycle response upstream.
- Latches address and write data at request acceptance, so upstream may change inputs after acceptance.

Parameters:
LINE_W, 256, cache line width in bits
BURST_W, 64, memory beat width in bits; LINE_W must be an integer multiple
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
u_read  input  1  upstream line read request, level, held until u_resp
u_write  input  1  upstream line write request, level, held until u_resp
u_address  input  ADDR_W  upstream byte address
u_wdata  input  LINE_W  line to write
u_rdata  output  LINE_W  assembled read line
u_resp  output  1  one-cycle completion pulse
m_read  output  1  burst read request to memory
m_write  output  1  burst write request to memory
m_address  output  ADDR_W  line-aligned burst address
m_wdata  output  BURST_W  current write beat
m_rdata  input  BURST_W  current read beat, valid when m_resp=1
m_resp  input  1  memory beat handshake; one beat per asserted cycle

Behaviour:
- Definitions:
  - BEATS = LINE_W/BURST_W (default 4).
  - OFF = log2(LINE_W/8) (default 5).
  - Beat counter width is log2(BEATS).
- Reset (async, immediate):
  - state=IDLE, beat=0.
  - Address and write-data latches = 0; u_rdata = 0.
  - u_resp, m_read, m_write = 0.
  - Reset mid-burst abandons the transaction and drops m_read/m_write in the same instant.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If u_read: latch {u_address[ADDR_W-1:OFF], OFF zeros}, beat=0, go READ.
  - Else if u_write: latch the same address and u_wdata, beat=0, go WRITE.
  - If u_read and u_write are both asserted (illegal upstream), read wins.
  - m_resp in IDLE is ignored.
- READ:
  - m_read=1; m_address = latched address.
  - On each cycle with m_resp=1: u_rdata[beat*BURST_W +: BURST_W] <= m_rdata, beat++.
  - Beats fill from least significant first.
  - Gaps (m_resp low) between beats are legal; the state waits.
  - On the m_resp cycle with beat==BEATS-1: beat wraps to 0, go DONE.
  - m_read stays high through that cycle and is low from DONE onward.
- WRITE:
  - m_write=1; m_wdata = latched line slice [beat*BURST_W +: BURST_W]; combinational on beat.
  - Each m_resp cycle consumes the current beat, then beat++.
  - After the last beat: wrap to 0, go DONE.
- DONE:
  - u_resp=1 for exactly one cycle, then return to IDLE.
  - u_rdata is valid in DONE and holds until the next read completes; writes do not alter it.
- Latency:
  - Request accepted in IDLE at cycle 0; m_read/m_write asserted from cycle 1.
  - With back-to-back m_resp starting at cycle 1, u_resp at cycle 1+BEATS (5 with defaults).
- Back-to-back requests: upstream drops its request on u_resp. A request still high in IDLE after DONE starts a new transaction, so there is a minimum of one idle cycle between transactions.
- Outputs other than u_rdata are 0 in any state where they are not listed above.
- m_address is 0 in IDLE and DONE.
- Upstream input changes after acceptance have no effect.

Test Plan:
- Reset, then read at u_address=0x0000_1234 with m_resp high cycles 1-4 and beats 0xA..A0, 0xB..B1, 0xC..C2, 0xD..D3. Required:
  - m_address=0x0000_1220.
  - m_read high cycles 1-4.
  - u_resp pulse at cycle 5.
  - u_rdata={D..D3,C..C2,B..B1,A..A0}.
- Write of line 0x0123..EF (256-bit) to 0x8000_0040 with m_resp high cycles 1-4. Required:
  - m_wdata equals line[63:0], [127:64], [191:128], [255:192] on cycles 1-4.
  - u_resp at cycle 5.
  - u_rdata unchanged.
- Read with m_resp gaps (beats at cycles 2, 5, 6, 9):
  - Beats captured only on m_resp cycles.
  - u_resp at cycle 10.
  - m_read continuous from cycle 1 through 9.
- u_read and u_write asserted together in IDLE:
  - Read transaction performed; m_write never asserted.
  - Stray m_resp while IDLE causes no state change.
- Assert rst mid-write after beat 2:
  - m_write drops immediately; no u_resp.
  - After release, a fresh read completes normally with beat counter starting at 0.
- Upstream changes u_address/u_wdata one cycle after acceptance: m_address and m_wdata still reflect the original values.
